// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer for the NPC206 next-PC unit.
// Define IFU_TIMEOUT_EN to add the WAIT-state response timeout and the sticky ERR state.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] next_i_addr,
   output logic [29:0] pc_addr,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_err
);

   localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

`ifdef IFU_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID} state_t;
`endif

   state_t      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;

`ifdef IFU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wait_cnt_q;
   logic          timeout_hit;

   // Counts WAIT cycles without a response; a response on the final cycle still wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else if (state_q == REQ && imem_gnt) begin
         wait_cnt_q <= '0;
      end else if (state_q == WAIT && !imem_rvalid) begin
         wait_cnt_q <= wait_cnt_q + CW'(1);
      end
   end

   assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_WORD;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // The PC only moves on the decode handshake, so NPC206 sees it stable for the whole fetch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (imem_gnt) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = VALID;
            end
`ifdef IFU_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d = ERR;
            end
`endif
         end
         VALID: begin
            if (instr_ready) begin
               pc_d    = next_i_addr;
               state_d = REQ;
            end
         end
`ifdef IFU_TIMEOUT_EN
         ERR: begin
            state_d = ERR;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pc_addr     = pc_q;
   assign imem_addr   = pc_q;
   assign imem_req    = (state_q == REQ);
   assign instr       = instr_q;
   assign instr_valid = (state_q == VALID);
`ifdef IFU_TIMEOUT_EN
   assign fetch_err   = (state_q == ERR);
`else
   assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a transaction-level schedule produces per-cycle
// stimulus and expected outputs; honours IFU_TIMEOUT_EN when it is defined for the build.
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [29:0] RESET_WORD = 30'h0C00;
   localparam int          TIMEOUT    = 16;

   logic        clk;
   logic        rst_n;
   logic [29:0] next_i_addr;
   logic [29:0] pc_addr;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_err;

   pc_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .next_i_addr(next_i_addr), .pc_addr(pc_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_err(fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic [29:0] nxt;
      logic        e_req;
      logic        e_valid;
      logic [29:0] e_pc;
      logic [31:0] e_instr;
      logic        e_err;
   } entry_t;

   entry_t      tbl[$];
   logic [29:0] m_pc;
   logic [31:0] m_instr;
   int          tests_run;
   int          tests_failed;
   int          idx_first_req, idx_first_valid, idx_second_req, idx_refetch_req;

   // Inputs driven at the end of the entry; expectations are what the outputs show before that.
   task automatic push(input logic rst, input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic ready, input logic [29:0] nxt,
                       input logic e_req, input logic e_valid, input logic e_err);
      entry_t e;
      e.rst = rst; e.gnt = gnt; e.rvalid = rvalid; e.rdata = rdata; e.ready = ready; e.nxt = nxt;
      e.e_req = e_req; e.e_valid = e_valid; e.e_pc = m_pc; e.e_instr = m_instr; e.e_err = e_err;
      tbl.push_back(e);
   endtask

   task automatic add_reset(input int n);
      m_pc    = RESET_WORD;
      m_instr = 32'h0;
      for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 30'h1, 1'b0, 1'b0, 1'b0);
      push(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 30'h2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic add_req(input int g);
      for (int i = 0; i <= g; i++)
         push(1'b1, (i == g), (i == 0 && g > 0), 32'hDEAD_0000 + i, 1'b1, 30'h2AAA_0000 + i,
              1'b1, 1'b0, 1'b0);
   endtask

   task automatic add_txn(input int g, input int r, input int d, input logic [31:0] data,
                          input logic [29:0] nxt);
      add_req(g);
      for (int j = 0; j <= r; j++)
         push(1'b1, (j != r), (j == r), (j == r) ? data : 32'hBAD0_0000 + j, 1'b1, ~nxt,
              1'b0, 1'b0, 1'b0);
      m_instr = data;
      for (int k = 0; k <= d; k++)
         push(1'b1, 1'b1, (k != d), 32'h5A5A_0000 + k, (k == d),
              (k == d) ? nxt : (nxt ^ 30'h155) + 30'(k), 1'b0, 1'b1, 1'b0);
      m_pc = nxt;
   endtask

   // Fetch that is abandoned by asserting reset partway through WAIT.
   task automatic add_abort(input int g, input int w);
      add_req(g);
      for (int j = 0; j < w; j++) push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0);
   endtask

`ifdef IFU_TIMEOUT_EN
   task automatic add_timeout();
      add_req(0);
      for (int j = 0; j < TIMEOUT; j++) push(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 30'h3, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) push(1'b1, 1'b1, 1'b1, 32'h7777_7777, 1'b1, 30'h3, 1'b0, 1'b0, 1'b1);
      push(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b1);
   endtask
`endif

   task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s at entry %0d: got %h, expected %h", name, c, act, req);
      end
   endtask

   task automatic checkOutput(input int c);
      cmp("imem_req", c, 32'(imem_req), 32'(tbl[c].e_req));
      cmp("instr_valid", c, 32'(instr_valid), 32'(tbl[c].e_valid));
      cmp("pc_addr", c, 32'(pc_addr), 32'(tbl[c].e_pc));
      cmp("imem_addr", c, 32'(imem_addr), 32'(tbl[c].e_pc));
      cmp("instr", c, instr, tbl[c].e_instr);
      cmp("fetch_err", c, 32'(fetch_err), 32'(tbl[c].e_err));
   endtask

   task automatic checkReset(input int c);
      cmp("async_rst_req", c, 32'(imem_req), 32'h0);
      cmp("async_rst_valid", c, 32'(instr_valid), 32'h0);
      cmp("async_rst_pc", c, 32'(pc_addr), 32'h0000_0C00);
      cmp("async_rst_instr", c, instr, 32'h0);
      cmp("async_rst_err", c, 32'(fetch_err), 32'h0);
   endtask

   task automatic applyStimulus(input int c);
      rst_n       = tbl[c].rst;
      imem_gnt    = tbl[c].gnt;
      imem_rvalid = tbl[c].rvalid;
      imem_rdata  = tbl[c].rdata;
      instr_ready = tbl[c].ready;
      next_i_addr = tbl[c].nxt;
   endtask

   initial begin
      logic prev_rst;
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0; next_i_addr = '0;
      #1 rst_n = 1'b0;

      add_reset(2);
      idx_first_req = tbl.size();
      add_txn(0, 0, 0, 32'h2408_0005, 30'h0C01);
      idx_first_valid = idx_first_req + 2;
      idx_second_req = tbl.size();
      add_txn(3, 1, 0, 32'h1111_2222, 30'h0C02);
      add_txn(0, 0, 5, 32'h3333_4444, 30'h0C03);
      add_txn(1, 2, 1, 32'h5555_6666, 30'h3FFF_FFFF);
      add_txn(0, 0, 0, 32'h7777_8888, 30'h0000_0000);
`ifdef IFU_TIMEOUT_EN
      add_txn(0, TIMEOUT - 1, 0, 32'h9999_AAAA, 30'h0123);
`else
      add_txn(0, 20, 0, 32'h9999_AAAA, 30'h0123);
`endif
      add_abort(2, 3);
      add_reset(2);
      idx_refetch_req = tbl.size();
      add_txn(0, 0, 0, 32'hCAFE_F00D, 30'h0C10);
`ifdef IFU_TIMEOUT_EN
      add_timeout();
      add_reset(1);
      add_txn(0, 1, 0, 32'h0BAD_BEEF, 30'h0C20);
`endif
      push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0, 1'b1, 1'b0, 1'b0);

      prev_rst = 1'b0;
      for (int c = 0; c < tbl.size(); c++) begin
         @(negedge clk);
         checkOutput(c);
         if (c == idx_first_req) begin
            cmp("lit_first_req", c, 32'(imem_req), 32'h1);
            cmp("lit_reset_pc", c, 32'(pc_addr), 32'h0000_0C00);
         end
         if (c == idx_first_valid) cmp("lit_first_instr", c, instr, 32'h2408_0005);
         if (c == idx_second_req) cmp("lit_next_pc", c, 32'(imem_addr), 32'h0000_0C01);
         if (c == idx_refetch_req) cmp("lit_refetch_pc", c, 32'(pc_addr), 32'h0000_0C00);
         applyStimulus(c);
         if (prev_rst && !tbl[c].rst) begin
            #1 checkReset(c);
         end
         prev_rst = tbl[c].rst;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
